// File: rtl/bip_control_if.sv
`default_nettype none
// =============================================================================
// Module   : bip_control_if
// Brief    : Bus bundle between the BIP control unit and the CPU core/memories.
// Revision : 1.0
// =============================================================================
interface bip_control_if #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16
);
  logic               i_enable;
  logic [NBITS_D-1:0] i_Instruction;
  logic [NBITS_O-1:0] o_PcAddr;
  logic [NBITS_O-1:0] o_Operand;
  logic [1:0]         o_SelA;
  logic               o_SelB;
  logic               o_Op;
  logic               o_WrAcc;
  logic               o_WrRam;
  logic               o_RdRam;
  logic               o_Halt;
  logic [NBITS_D-1:0] o_CycleCount;

  modport master (
    input  i_enable, i_Instruction,
    output o_PcAddr, o_Operand, o_SelA, o_SelB, o_Op,
           o_WrAcc, o_WrRam, o_RdRam, o_Halt, o_CycleCount
  );

  modport slave (
    output i_enable, i_Instruction,
    input  o_PcAddr, o_Operand, o_SelA, o_SelB, o_Op,
           o_WrAcc, o_WrRam, o_RdRam, o_Halt, o_CycleCount
  );
endinterface
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// =============================================================================
// Module   : bip_control
// Brief    : Multicycle fetch/decode control unit for the accumulator BIP CPU.
// Revision : 1.0
// =============================================================================
module bip_control #(
  parameter int NBITS_O = 11,
  parameter int NBITS_E = 5,
  parameter int NBITS_D = 16
) (
  input  wire logic     i_clock,
  input  wire logic     i_reset,
  bip_control_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM    = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [NBITS_E-1:0] c_opHlt  = NBITS_E'(0);
  localparam logic [NBITS_E-1:0] c_opSto  = NBITS_E'(1);
  localparam logic [NBITS_E-1:0] c_opLd   = NBITS_E'(2);
  localparam logic [NBITS_E-1:0] c_opLdi  = NBITS_E'(3);
  localparam logic [NBITS_E-1:0] c_opAdd  = NBITS_E'(4);
  localparam logic [NBITS_E-1:0] c_opAddi = NBITS_E'(5);
  localparam logic [NBITS_E-1:0] c_opSub  = NBITS_E'(6);
  localparam logic [NBITS_E-1:0] c_opSubi = NBITS_E'(7);

  state_t             r_state;
  logic [NBITS_O-1:0] r_pc;
  logic [NBITS_O-1:0] r_irOperand;
  logic [NBITS_D-1:0] r_count;
  logic [1:0]         r_selA;
  logic               r_selB;
  logic               r_op;
  logic               r_rdRam;
  logic               r_wrAcc;
  logic               r_wrRam;
  logic               r_halt;

  logic [NBITS_E-1:0] w_opcode;
  logic [1:0]         w_selA;
  logic               w_selB;
  logic               w_op;
  logic               w_isMem;
  logic               w_immWrAcc;
  logic               w_isSto;

  assign w_opcode = bus.i_Instruction[NBITS_D-1 -: NBITS_E];

  // Decode straight from program-memory data so selects are latched with IR.
  always_comb begin
    w_selA     = 2'b00;
    w_selB     = 1'b0;
    w_op       = 1'b0;
    w_isMem    = 1'b0;
    w_immWrAcc = 1'b0;
    w_isSto    = 1'b0;
    case (w_opcode)
      c_opSto:  w_isSto = 1'b1;
      c_opLd:   w_isMem = 1'b1;
      c_opLdi:  begin w_selA = 2'b01; w_immWrAcc = 1'b1; end
      c_opAdd:  begin w_selA = 2'b10; w_isMem = 1'b1; end
      c_opAddi: begin w_selA = 2'b10; w_selB = 1'b1; w_immWrAcc = 1'b1; end
      c_opSub:  begin w_selA = 2'b10; w_op = 1'b1; w_isMem = 1'b1; end
      c_opSubi: begin w_selA = 2'b10; w_selB = 1'b1; w_op = 1'b1; w_immWrAcc = 1'b1; end
      default:  ;
    endcase
  end

  // Strobe flags are set on entry to MEM/EXEC and cleared on exit, so each
  // fires for exactly one enabled cycle no matter how long a stall lasts.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= FETCH;
      r_pc        <= '0;
      r_irOperand <= '0;
      r_count     <= '0;
      r_selA      <= 2'b00;
      r_selB      <= 1'b0;
      r_op        <= 1'b0;
      r_rdRam     <= 1'b0;
      r_wrAcc     <= 1'b0;
      r_wrRam     <= 1'b0;
      r_halt      <= 1'b0;
    end else if (bus.i_enable) begin
      if (r_state != HALT) begin
        r_count <= r_count + NBITS_D'(1);
      end
      case (r_state)
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_irOperand <= bus.i_Instruction[NBITS_O-1:0];
          r_selA      <= w_selA;
          r_selB      <= w_selB;
          r_op        <= w_op;
          if (w_opcode == c_opHlt) begin
            r_state <= HALT;
            r_halt  <= 1'b1;
          end else if (w_isMem) begin
            r_state <= MEM;
            r_rdRam <= 1'b1;
          end else begin
            r_state <= EXEC;
            r_wrAcc <= w_immWrAcc;
            r_wrRam <= w_isSto;
          end
        end
        MEM: begin
          r_state <= EXEC;
          r_rdRam <= 1'b0;
          r_wrAcc <= 1'b1;
        end
        EXEC: begin
          r_state <= FETCH;
          r_pc    <= r_pc + NBITS_O'(1);
          r_wrAcc <= 1'b0;
          r_wrRam <= 1'b0;
        end
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign bus.o_PcAddr     = r_pc;
  assign bus.o_Operand    = r_irOperand;
  assign bus.o_SelA       = r_selA;
  assign bus.o_SelB       = r_selB;
  assign bus.o_Op         = r_op;
  assign bus.o_RdRam      = r_rdRam & bus.i_enable;
  assign bus.o_WrAcc      = r_wrAcc & bus.i_enable;
  assign bus.o_WrRam      = r_wrRam & bus.i_enable;
  assign bus.o_Halt       = r_halt;
  assign bus.o_CycleCount = r_count;

endmodule
`default_nettype wire

// File: doc/bip_control.md
# bip_control

Control unit for the accumulator-based BIP processor; it is the instruction-side counterpart to `datapath`. It owns the program counter and fetches 16-bit instructions from program memory. It decodes each instruction with a small multicycle FSM and drives every `datapath` control input (`SelA`, `SelB`, `WrAcc`, `Op`, `Operand`) plus the data-memory strobes. It sits between program memory, data memory and `datapath` inside the CPU top.

## Interface
- `NBITS_O`, default 11: operand / address width; this is the PC width and the instruction operand field width.
- `NBITS_E`, default 5: opcode field width.
- `NBITS_D`, default 16: instruction width (`NBITS_E + NBITS_O`) and cycle-counter width.
- `i_clock`, in, 1: single clock; everything is rising-edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_enable`, in, 1: run enable. Low stalls the FSM, PC, IR and counter.
- `i_Instruction`, in, NBITS_D: program-memory read data. Opcode is bits [15:11]; operand is bits [10:0].
- `o_PcAddr`, out, NBITS_O: program-memory address, equal to the PC.
- `o_Operand`, out, NBITS_O: IR operand field, sent to `datapath` and used as the data-memory address.
- `o_SelA`, out, 2: accumulator input mux select. 00 = data memory, 01 = sign-extended operand, 10 = ALU result.
- `o_SelB`, out, 1: ALU B-input select. 0 = data memory, 1 = sign-extended operand.
- `o_Op`, out, 1: ALU operation. 0 = add, 1 = subtract.
- `o_WrAcc`, out, 1: accumulator write strobe.
- `o_WrRam`, out, 1: data-memory write strobe (stores the accumulator).
- `o_RdRam`, out, 1: data-memory read strobe.
- `o_Halt`, out, 1: high once HLT has been executed.
- `o_CycleCount`, out, NBITS_D: count of enabled, non-halted cycles.

## Operation
- Opcodes:
  - 00000 HLT
  - 00001 STO
  - 00010 LD
  - 00011 LDI
  - 00100 ADD
  - 00101 ADDI
  - 00110 SUB
  - 00111 SUBI
  - All others are NOP.
- FSM states and transitions (each transition occurs only on a clock edge with `i_enable`=1):
  - FETCH → DECODE.
  - DECODE: latch `i_Instruction` into IR, then go to HALT (HLT), MEM (LD/ADD/SUB) or EXEC (all other opcodes).
  - MEM → EXEC.
  - EXEC → FETCH, with PC ← PC+1.
  - HALT is terminal; only reset leaves it.
- Strobes and selects by state (all strobes are ANDed with `i_enable`):
  - MEM: `o_RdRam`=1.
  - EXEC: `o_WrAcc`=1 for LD, LDI, ADD, ADDI, SUB, SUBI; `o_WrRam`=1 for STO; NOP drives no strobe.
- Select values during EXEC:
  - LD: `SelA`=00.
  - LDI: `SelA`=01.
  - ADD: `SelA`=10, `SelB`=0, `Op`=0.
  - ADDI: `SelA`=10, `SelB`=1, `Op`=0.
  - SUB: `SelA`=10, `SelB`=0, `Op`=1.
  - SUBI: `SelA`=10, `SelB`=1, `Op`=1.
- `SelA`, `SelB` and `Op` are decoded from IR. They are valid from MEM/EXEC until the end of the next DECODE. Their values outside EXEC are don't-care for the datapath but must be deterministic.
- The PC wraps from 2^NBITS_O−1 to 0 with no flag.
- `o_CycleCount` increments on every edge with `i_enable`=1 and the state not HALT. It wraps modulo 2^NBITS_D.
- `o_Halt` is 1 in HALT. It stays sticky; `i_enable` has no effect on it.
- Reset values:
  - State FETCH.
  - PC = 0, IR = 0, count = 0.
  - All strobes = 0, `SelA`=00, `SelB`=0, `Op`=0, `o_Halt`=0, `o_Operand`=0.

## Timing
- Program memory has a synchronous 1-cycle read: the address is presented in FETCH and data is valid throughout DECODE.
- Data memory has a synchronous 1-cycle read: the read is issued in MEM and data is valid in EXEC. `datapath` captures the accumulator on the EXEC edge.
- Instruction latency in cycles: LD/ADD/SUB take 4 (FETCH, DECODE, MEM, EXEC). LDI/ADDI/SUBI/STO/NOP take 3. HLT reaches HALT 2 cycles after its FETCH.
- Every write strobe is high for exactly one enabled cycle per instruction.
- Stall rule: if `i_enable` drops in any state, all state is held and strobes go low combinationally. On resume, the strobe reasserts for exactly one cycle.
- Asynchronous reset, at any time including mid-EXEC: strobes and `o_Halt` drop immediately, without waiting for a clock edge. The first FETCH after deassertion presents PC=0.

## Test plan
- LDI then HLT. Program {LDI 0x07B, HLT}. Required: `o_WrAcc` pulses once with `SelA`=01 and `o_Operand`=0x07B. `o_Halt` rises; PC stays at 1.
- LD/ADD/SUB memory ops. Program {LD 3, ADD 4, SUB 5, HLT}. Required: `o_RdRam` is high in each MEM with `o_Operand` = 3, 4, 5. `WrAcc` selects are 00, then 10/0/0, then 10/0/1. `o_CycleCount` = 14 when halted.
- STO and immediates. Program {ADDI 1, SUBI 2, STO 0x10, HLT}. Required: selects are 10/1/0, then 10/1/1. `o_WrRam` pulses once with `o_Operand`=0x010 and `o_WrAcc`=0 during STO.
- Stall. Drop `i_enable` for 5 cycles while in EXEC of an ADD. Required: `o_WrAcc` is low for those cycles and pulses exactly once after resume. PC and count are frozen during the stall.
- Reset mid-operation. Assert `i_reset` between clock edges during EXEC of LDI. Required: `o_WrAcc` falls immediately. After release: `o_PcAddr`=0, `o_CycleCount`=0, `o_Halt`=0.
- PC wrap and NOP. Fill program memory with NOP (opcode 01000) and run 2049 instructions. Required: PC goes 0x7FF → 0x000, and no strobe is ever asserted.
